// File: rtl/bcd_clock_counter.sv
// HH:MM:SS real-time counter with every field held as 2-digit BCD.
// The hour is stored internally in 24 h form. The 12/24 h presentation on
// hour/pm is derived combinationally, so changing mode never alters the time.
// Per-edge priority is: parallel load > field set > run count > hold.
module bcd_clock_counter #(
    parameter logic [7:0] RST_HH = 8'h00,
    parameter logic [7:0] RST_MM = 8'h00,
    parameter logic [7:0] RST_SS = 8'h00
) (
    input  logic       clk_1hz,
    input  logic       rst_n,
    input  logic       run_en,
    input  logic       mode_12h,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       pm,
    output logic       day_tick,
    output logic       load_err
);

    // Operating mode is decoded fresh from the inputs on every cycle.
    // SET overrides run_en, and leaving SET resumes on the next edge
    // without skipping or repeating a second.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } mode_e;

    mode_e      mode;
    logic [7:0] hh_q, mm_q, ss_q;
    logic [7:0] hh_d, mm_d, ss_d;
    logic       day_tick_q, day_tick_d;
    logic       load_err_q, load_err_d;
    logic       load_ok;

    // BCD increment with wrap at max.
    // The ones digit rolls 9->0 and carries into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A value is valid BCD in range when both nibbles are <= 9 and it is <= max.
    // With legal nibbles, a plain compare orders BCD values correctly.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    assign load_ok = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);

    // Decode the operating mode; set_sel != 00 wins over run_en.
    always_comb begin
        if (set_sel != 2'b00)
            mode = SET;
        else if (run_en)
            mode = RUN;
        else
            mode = IDLE;
    end

    // Next-state logic for the time fields and the one-cycle pulses.
    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        day_tick_d = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            // A rejected load leaves all fields alone, including the count.
            if (load_ok) begin
                hh_d = load_hh;
                mm_d = load_mm;
                ss_d = load_ss;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (mode)
                SET: begin
                    // Set only touches the selected field: no carry, no day_tick.
                    if (set_inc) begin
                        unique case (set_sel)
                            2'b01:   ss_d = bcd_inc(ss_q, 8'h59);
                            2'b10:   mm_d = bcd_inc(mm_q, 8'h59);
                            2'b11:   hh_d = bcd_inc(hh_q, 8'h23);
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd_inc(mm_q, 8'h59);
                        if (mm_q == 8'h59) begin
                            hh_d = bcd_inc(hh_q, 8'h23);
                            if (hh_q == 8'h23)
                                day_tick_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Time and pulse registers; reset forces the RST_* time and clears the pulses.
    // NOTE: clocked state uses non-blocking assignment, so every register
    // samples the pre-edge values.
    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            hh_q       <= RST_HH;
            mm_q       <= RST_MM;
            ss_q       <= RST_SS;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

    // Hour presentation.
    // In 12 h mode: 00->12, 01-12 unchanged, 13-23 shown as h-12 in BCD.
    always_comb begin
        hour = hh_q;
        if (mode_12h) begin
            if (hh_q == 8'h00)
                hour = 8'h12;
            else if (hh_q >= 8'h13 && hh_q <= 8'h19)
                hour = {4'h0, hh_q[3:0] - 4'd2};
            else if (hh_q == 8'h20 || hh_q == 8'h21)
                hour = {4'h0, hh_q[3:0] + 4'd8};
            else if (hh_q == 8'h22 || hh_q == 8'h23)
                hour = {4'h1, hh_q[3:0] - 4'd2};
        end
    end

    assign pm       = (hh_q >= 8'h12);
    assign minute   = mm_q;
    assign second   = ss_q;
    assign day_tick = day_tick_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Scoreboard bench for bcd_clock_counter.
// Stimulus drives each cycle's inputs and queues the expected post-edge
// outputs. The monitor pops one entry per cycle and compares it.
// A second instance with RST_HH=8'h12 covers the non-default reset value.
module tb_bcd_clock_counter;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
        logic       pm;
        logic       day_tick;
        logic       load_err;
    } exp_t;

    logic       clk_1hz = 1'b0;
    logic       rst_n   = 1'b0;
    logic       run_en  = 1'b0;
    logic       mode_12h = 1'b0;
    logic [1:0] set_sel = 2'b00;
    logic       set_inc = 1'b0;
    logic       load    = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;

    logic [7:0] hour0, minute0, second0, hour1, minute1, second1;
    logic       pm0, day_tick0, load_err0, pm1, day_tick1, load_err1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    bcd_clock_counter dut0 (
        .clk_1hz(clk_1hz), .rst_n(rst_n), .run_en(run_en), .mode_12h(mode_12h),
        .set_sel(set_sel), .set_inc(set_inc), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hour(hour0), .minute(minute0), .second(second0), .pm(pm0),
        .day_tick(day_tick0), .load_err(load_err0)
    );

    bcd_clock_counter #(.RST_HH(8'h12), .RST_MM(8'h00), .RST_SS(8'h00)) dut1 (
        .clk_1hz(clk_1hz), .rst_n(rst_n), .run_en(run_en), .mode_12h(mode_12h),
        .set_sel(set_sel), .set_inc(set_inc), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hour(hour1), .minute(minute1), .second(second1), .pm(pm1),
        .day_tick(day_tick1), .load_err(load_err1)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h pm=%b dt=%b le=%b, want %h:%h:%h pm=%b dt=%b le=%b",
                     name, act.hour, act.minute, act.second, act.pm, act.day_tick, act.load_err,
                     req.hour, req.minute, req.second, req.pm, req.day_tick, req.load_err);
        end
    endtask

    function automatic exp_t snap0();
        return '{hour0, minute0, second0, pm0, day_tick0, load_err0};
    endfunction

    function automatic exp_t snap1();
        return '{hour1, minute1, second1, pm1, day_tick1, load_err1};
    endfunction

    // Drive one cycle of inputs, then queue the expected outputs after the next edge.
    task automatic step(input logic r, input logic m12, input logic [1:0] sel, input logic inc,
                        input logic ld, input logic [7:0] lh, input logic [7:0] lm,
                        input logic [7:0] ls, input exp_t e);
        @(negedge clk_1hz);
        #1;
        run_en = r; mode_12h = m12; set_sel = sel; set_inc = inc;
        load = ld; load_hh = lh; load_mm = lm; load_ss = ls;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs settle after each posedge and are compared at the negedge.
    initial begin
        forever begin
            @(negedge clk_1hz);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("cycle@%0t", $time), snap0(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of both instances.
        @(negedge clk_1hz);
        @(negedge clk_1hz);
        check("reset_default", snap0(), '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        check("reset_rst_hh12", snap1(), '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        #1 rst_n = 1'b1;

        // Idle for five clocks: the time holds.
        for (int i = 0; i < 5; i++)
            step(0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});

        // Day rollover.
        step(0, 0, 2'b00, 0, 1, 8'h23, 8'h59, 8'h58, '{8'h23, 8'h59, 8'h58, 1'b1, 1'b0, 1'b0});
        step(1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h23, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0});
        step(1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
        step(0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});

        // 12 h mapping; toggling the mode leaves minute/second unchanged.
        step(0, 1, 2'b00, 0, 1, 8'h13, 8'h05, 8'h09, '{8'h01, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0});
        step(0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h13, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h01, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h00, 8'h30, 8'h00, '{8'h12, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h12, 8'h45, 8'h00, '{8'h12, 8'h45, 8'h00, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h09, 8'h00, 8'h00, '{8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h19, 8'h00, 8'h00, '{8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h20, 8'h00, 8'h00, '{8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h22, 8'h00, 8'h00, '{8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        step(0, 1, 2'b00, 0, 1, 8'h23, 8'h10, 8'h00, '{8'h11, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0});

        // SET: the selected field wraps without carry; counting pauses even with run_en=1.
        step(0, 0, 2'b00, 0, 1, 8'h10, 8'h59, 8'h30, '{8'h10, 8'h59, 8'h30, 1'b0, 1'b0, 1'b0});
        step(1, 0, 2'b10, 1, 0, 8'h00, 8'h00, 8'h00, '{8'h10, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0});
        step(1, 0, 2'b10, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h10, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0});
        step(1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h10, 8'h00, 8'h31, 1'b0, 1'b0, 1'b0});
        step(0, 0, 2'b00, 0, 1, 8'h23, 8'h00, 8'h00, '{8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        step(1, 0, 2'b11, 1, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        step(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 8'h59, '{8'h00, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0});
        step(0, 0, 2'b01, 1, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        step(0, 0, 2'b00, 1, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});

        // Rejected loads: no field changes (count skipped too); load_err pulses for one cycle.
        step(0, 0, 2'b00, 0, 1, 8'h24, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
        step(0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        step(1, 0, 2'b00, 0, 1, 8'h12, 8'h6A, 8'h00, '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
        step(1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0});
        step(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 8'h60, '{8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1});
        // A load on the same edge as a set increment: the load wins.
        step(1, 0, 2'b11, 1, 1, 8'h05, 8'h06, 8'h07, '{8'h05, 8'h06, 8'h07, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset in the middle of a RUN.
        step(0, 0, 2'b00, 0, 1, 8'h07, 8'h30, 8'h15, '{8'h07, 8'h30, 8'h15, 1'b0, 1'b0, 1'b0});
        step(1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, '{8'h07, 8'h30, 8'h16, 1'b0, 1'b0, 1'b0});
        @(negedge clk_1hz);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_default", snap0(), '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        check("async_reset_rst_hh12", snap1(), '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        @(negedge clk_1hz);
        #1 rst_n = 1'b1;
        sb_q.push_back('{8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0});
        @(negedge clk_1hz);
        #2;
        check("resume_rst_hh12", snap1(), '{8'h12, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0});
        run_en = 1'b0;

        // Drain the scoreboard, with a bound on the wait.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++)
            @(negedge clk_1hz);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
